// File: rtl/ysyx_22040750_pipe_stage_buf.sv
// Parametrised pipeline-stage register: DEPTH-entry FIFO with valid/allowin handshake,
// multicycle gating via I_done, synchronous flush and a first-cycle-at-head pulse.
module ysyx_22040750_pipe_stage_buf #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 3
) (
    input  logic              I_sys_clk,
    input  logic              I_rst_n,
    input  logic              I_flush,
    input  logic              I_in_valid,
    output logic              O_allowin,
    input  logic [DATA_W-1:0] I_data,
    input  logic              I_done,
    input  logic              I_allowout,
    output logic              O_valid,
    output logic [DATA_W-1:0] O_data,
    output logic              O_head_valid,
    output logic              O_head_new,
    output logic [CNT_W-1:0]  O_count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              head_new;
    logic              head_valid;
    logic              push;
    logic              pop;

    // Explicit wrap so non-power-of-two depths (e.g. 3) stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_valid = (count != '0);
    assign pop        = head_valid && I_done && I_allowout;
    assign push       = I_in_valid && O_allowin;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // Single entry keeps the legacy combinational allowin; deeper buffers decouple
    // upstream timing from the downstream handshake.
    generate
        if (DEPTH == 1) begin : g_single
            assign O_allowin = !head_valid || (I_done && I_allowout);
        end else begin : g_multi
            assign O_allowin = (count < DEPTH_C);
        end
    endgenerate

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            head_new <= 1'b0;
        end else if (I_flush) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            head_new <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count    <= count_next;
            head_new <= (push && (count == '0)) || (pop && (count_next != '0));
        end
    end

    // Payload storage only changes on an accepted push.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !I_flush) begin
            mem[wr_ptr] <= I_data;
        end
    end

    assign O_data       = mem[rd_ptr];
    assign O_head_valid = head_valid;
    assign O_valid      = head_valid && I_done;
    assign O_head_new   = head_new;
    assign O_count      = count;

endmodule

// File: tb/tb_ysyx_22040750_pipe_stage_buf.sv
// Directed bench for ysyx_22040750_pipe_stage_buf at DEPTH 1, 2 and 4.
module tb_ysyx_22040750_pipe_stage_buf;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    logic        v1, dn1, ao1, fl1, a1, ov1, hv1, hn1;
    logic [15:0] di1, od1;
    logic [2:0]  oc1;
    logic        v2, dn2, ao2, fl2, a2, ov2, hv2, hn2;
    logic [15:0] di2, od2;
    logic [2:0]  oc2;
    logic        v4, dn4, ao4, fl4, a4, ov4, hv4, hn4;
    logic [15:0] di4, od4;
    logic [2:0]  oc4;

    ysyx_22040750_pipe_stage_buf #(.DATA_W(16), .DEPTH(1), .CNT_W(3)) u_d1 (
        .I_sys_clk(clk), .I_rst_n(rst_n), .I_flush(fl1), .I_in_valid(v1), .O_allowin(a1),
        .I_data(di1), .I_done(dn1), .I_allowout(ao1), .O_valid(ov1), .O_data(od1),
        .O_head_valid(hv1), .O_head_new(hn1), .O_count(oc1));

    ysyx_22040750_pipe_stage_buf #(.DATA_W(16), .DEPTH(2), .CNT_W(3)) u_d2 (
        .I_sys_clk(clk), .I_rst_n(rst_n), .I_flush(fl2), .I_in_valid(v2), .O_allowin(a2),
        .I_data(di2), .I_done(dn2), .I_allowout(ao2), .O_valid(ov2), .O_data(od2),
        .O_head_valid(hv2), .O_head_new(hn2), .O_count(oc2));

    ysyx_22040750_pipe_stage_buf #(.DATA_W(16), .DEPTH(4), .CNT_W(3)) u_d4 (
        .I_sys_clk(clk), .I_rst_n(rst_n), .I_flush(fl4), .I_in_valid(v4), .O_allowin(a4),
        .I_data(di4), .I_done(dn4), .I_allowout(ao4), .O_valid(ov4), .O_data(od4),
        .O_head_valid(hv4), .O_head_new(hn4), .O_count(oc4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  sent, rcvd, exp_cnt, cyc;
        bit  push, pop;

        rst_n = 1'b0;
        {v1, dn1, ao1, fl1} = 4'b0; di1 = '0;
        {v2, dn2, ao2, fl2} = 4'b0; di2 = '0;
        {v4, dn4, ao4, fl4} = 4'b0; di4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",    32'(ov1), 32'd0);
        chk("rst_headv",    32'(hv1), 32'd0);
        chk("rst_headnew",  32'(hn1), 32'd0);
        chk("rst_count",    32'(oc1), 32'd0);
        chk("rst_data",     32'(od1), 32'd0);
        chk("rst_allowin1", 32'(a1),  32'd1);
        chk("rst_allowin2", 32'(a2),  32'd1);
        chk("rst_count4",   32'(oc4), 32'd0);
        rst_n = 1'b1;

        // T1: DEPTH=1 back-to-back A,B,C
        dn1 = 1'b1; ao1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v1 = 1'b1; di1 = 16'hA + 16'(i);
            #1;
            chk("t1_allowin", 32'(a1), 32'd1);
            tick();
            chk("t1_data",    32'(od1), 32'hA + 32'(i));
            chk("t1_valid",   32'(ov1), 32'd1);
            chk("t1_headnew", 32'(hn1), 32'd1);
            chk("t1_count",   32'(oc1), 32'd1);
        end
        v1 = 1'b0;
        tick();
        chk("t1_empty_count",   32'(oc1), 32'd0);
        chk("t1_empty_valid",   32'(ov1), 32'd0);
        chk("t1_empty_headnew", 32'(hn1), 32'd0);

        // T2: DEPTH=1 multicycle head
        dn1 = 1'b0; v1 = 1'b1; di1 = 16'h5;
        tick();
        di1 = 16'h6;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t2_valid",   32'(ov1), 32'd0);
            chk("t2_headv",   32'(hv1), 32'd1);
            chk("t2_headnew", 32'(hn1), (c == 0) ? 32'd1 : 32'd0);
            chk("t2_allowin", 32'(a1),  32'd0);
            chk("t2_data",    32'(od1), 32'h5);
            tick();
        end
        dn1 = 1'b1; ao1 = 1'b0;
        #1;
        chk("t2_stall_valid",   32'(ov1), 32'd1);
        chk("t2_stall_allowin", 32'(a1),  32'd0);
        tick();
        chk("t2_stall_data", 32'(od1), 32'h5);
        ao1 = 1'b1;
        #1;
        chk("t2_release_allowin", 32'(a1), 32'd1);
        tick();
        chk("t2_next_data",    32'(od1), 32'h6);
        chk("t2_next_headnew", 32'(hn1), 32'd1);
        chk("t2_next_count",   32'(oc1), 32'd1);
        v1 = 1'b0;
        tick();
        chk("t2_drain", 32'(oc1), 32'd0);

        // T3: DEPTH=2 fill to full with downstream stalled
        dn2 = 1'b1; ao2 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            v2 = 1'b1; di2 = 16'(i);
            #1;
            chk("t3_allowin", 32'(a2), (i < 3) ? 32'd1 : 32'd0);
            tick();
            chk("t3_count", 32'(oc2), (i == 1) ? 32'd1 : 32'd2);
            chk("t3_head",  32'(od2), 32'd1);
        end
        chk("t3_headnew_full", 32'(hn2), 32'd0);
        v2 = 1'b0; ao2 = 1'b1;
        #1;
        chk("t3_full_allowin", 32'(a2), 32'd0);
        chk("t3_pop1_valid",   32'(ov2), 32'd1);
        tick();
        chk("t3_pop1_count",   32'(oc2), 32'd1);
        chk("t3_second_data",  32'(od2), 32'd2);
        chk("t3_second_new",   32'(hn2), 32'd1);
        chk("t3_allowin_back", 32'(a2),  32'd1);
        tick();
        chk("t3_drained_count", 32'(oc2), 32'd0);
        chk("t3_drained_headv", 32'(hv2), 32'd0);
        chk("t3_drained_new",   32'(hn2), 32'd0);

        // T4: DEPTH=4 ordering with random downstream stalls
        sent = 0; rcvd = 0; exp_cnt = 0; cyc = 0;
        dn4 = 1'b1;
        while (rcvd < 10 && cyc < 300) begin
            ao4 = ($urandom_range(0, 2) != 0);
            v4  = (sent < 10);
            di4 = 16'(sent);
            #1;
            chk("t4_allowin", 32'(a4),  32'(exp_cnt < 4));
            chk("t4_count",   32'(oc4), 32'(exp_cnt));
            push = v4 && (exp_cnt < 4);
            pop  = (exp_cnt > 0) && ao4;
            if (pop) begin
                chk("t4_order", 32'(od4), 32'(rcvd));
                rcvd++;
            end
            tick();
            exp_cnt = exp_cnt + int'(push) - int'(pop);
            if (push) sent++;
            cyc++;
        end
        v4 = 1'b0;
        chk("t4_all_received", 32'(rcvd), 32'd10);

        // T5: DEPTH=2 flush while full with push and pop requested
        ao2 = 1'b0; v2 = 1'b1; di2 = 16'h11;
        tick();
        di2 = 16'h22;
        tick();
        chk("t5_full", 32'(oc2), 32'd2);
        fl2 = 1'b1; di2 = 16'h33; ao2 = 1'b1;
        tick();
        fl2 = 1'b0; v2 = 1'b0;
        chk("t5_count",   32'(oc2), 32'd0);
        chk("t5_headv",   32'(hv2), 32'd0);
        chk("t5_headnew", 32'(hn2), 32'd0);
        chk("t5_valid",   32'(ov2), 32'd0);
        tick();
        chk("t5_stays_empty", 32'(oc2), 32'd0);
        v2 = 1'b1; di2 = 16'h44;
        tick();
        v2 = 1'b0;
        chk("t5_fresh_data",  32'(od2), 32'h44);
        chk("t5_fresh_count", 32'(oc2), 32'd1);
        tick();
        chk("t5_fresh_drain", 32'(oc2), 32'd0);

        // T6: asynchronous reset mid-cycle with two entries held
        ao2 = 1'b0; v2 = 1'b1; di2 = 16'h55;
        tick();
        di2 = 16'h66;
        tick();
        v2 = 1'b0;
        #1;
        chk("t6_pre_count", 32'(oc2), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid",   32'(ov2), 32'd0);
        chk("t6_count",   32'(oc2), 32'd0);
        chk("t6_headnew", 32'(hn2), 32'd0);
        chk("t6_data",    32'(od2), 32'd0);
        chk("t6_allowin", 32'(a2),  32'd1);
        tick();
        rst_n = 1'b1;
        v2 = 1'b1; di2 = 16'h7; ao2 = 1'b1; dn2 = 1'b1;
        #1;
        chk("t6_post_allowin", 32'(a2), 32'd1);
        tick();
        v2 = 1'b0;
        chk("t6_post_data",    32'(od2), 32'h7);
        chk("t6_post_valid",   32'(ov2), 32'd1);
        chk("t6_post_headnew", 32'(hn2), 32'd1);
        tick();
        chk("t6_post_drain", 32'(oc2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
